relu_maxpool2: RTL
==================

# relu_maxpool2

Post-convolution stage that consumes the 32-bit signed raster stream produced by the 3×3 convolution block (28-wide row stride, 26×26 valid outputs per frame). It discards wrap-around columns, applies ReLU, performs 2×2 stride-2 max-pooling, and requantises to 16-bit signed. It emits a 13×13 feature map per frame to the next layer.

## Interface
- IN_W, 28: row stride of input stream (positions per row, incl. invalid columns)
- VALID_W, 26: valid columns per row (col < VALID_W kept)
- VALID_H, 26: rows per frame
- DW_IN, 32: input sample width (signed)
- DW_OUT, 16: output sample width (signed)
- SHIFT, 12: requantisation right-shift
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; asynchronous and active-high
- in_valid  in  1  data_in valid this cycle; no backpressure
- data_in  in  DW_IN  signed conv result
- out_valid  out  1  data_out valid, single-cycle pulse
- data_out  out  DW_OUT  signed pooled/requantised value (always ≥ 0)
- frame_done  out  1  one-cycle pulse after last position of frame accepted

## Operation
- Counters col (0..IN_W-1), row (0..VALID_H-1) advance only on in_valid. col wraps IN_W-1→0 with row+1. row wraps VALID_H-1→0 at col IN_W-1 (frame end).
- Sample kept only if col < VALID_W; others (cols 26, 27) consumed and ignored.
- ReLU: r = (data_in < 0) ? 0 : data_in.
- Horizontal: even col → hold r in pair register; odd col → h = max(held, r).
- Even row, odd col: linebuf[col>>1] ← h (VALID_W/2 = 13 entries, DW_IN-1 bits unsigned).
- Odd row, odd col: m = max(linebuf[col>>1], h); requantise; register to data_out; pulse out_valid.
- Requantise: q = m >> SHIFT (logical, m ≥ 0); if q > 2^(DW_OUT-1)-1 then q = 32767 (saturate); no negative path.
- VALID_W and VALID_H must be even; odd values unsupported.
- 169 out_valid pulses per frame (VALID_W/2 × VALID_H/2), raster order.

## Timing
- Reset values: out_valid 0, data_out 0, frame_done 0, col 0, row 0, pair register 0. Line buffer not reset; every entry written on an even row before being read.
- Latency: out_valid high exactly 1 cycle after the in_valid cycle carrying the odd-row/odd-col sample.
- in_valid gaps of any length allowed; state held, outputs pulse only on the cycle after an accepted qualifying sample.
- frame_done: 1 cycle after the in_valid cycle at row VALID_H-1, col IN_W-1. Coincides with no out_valid (col 27 is not pooled).
- Back-to-back frames: next frame's first sample may arrive the cycle after the last sample; no bubble required.
- rst asserted mid-frame: counters and outputs clear immediately (asynchronous); next accepted sample is treated as row 0, col 0.

## Configuration
- RELU_MAXPOOL_ROUND_EN defined: q = (m + 2^(SHIFT-1)) >> SHIFT (round half up), then saturate. The addition must not overflow: compute in DW_IN+1 bits.
- Not defined: truncation, q = m >> SHIFT.

## Structure
- Shared package: default IN_W/VALID_W/VALID_H/DW_IN/DW_OUT/SHIFT constants (shared with conv stage), and the saturation limit constant.
- One sub-module: relu_pool_linebuf (13-entry register array, single write port, single async read port indexed by col>>1).

## Test plan
- Constant input 409600 every position, continuous in_valid → 169 outputs all 100; frame_done once after 728 samples.
- All inputs negative (-5000) → 169 outputs all 0.
- Input 2^31-1 everywhere → all outputs 32767 (saturated).
- Frame of zeros except data_in=819200 at row 3, col 5 → only output index (row 1, col 2) = 200; all others 0; values at cols 26/27 set to 2^31-1 have no effect.
- Value 6144 everywhere: without RELU_MAXPOOL_ROUND_EN → 1; with it → 2. Also random in_valid gaps (30% idle) → identical output sequence to gap-free run.
- rst pulsed at row 10 mid-frame, then a full frame streamed → exactly 169 correct outputs, no stale out_valid.

Source files
------------

// File: rtl/relu_maxpool2_pkg.sv
// Shared constants for the conv -> relu_maxpool2 pipeline plus the requantiser.
// Optional feature macro: RELU_MAXPOOL_ROUND_EN (round half up instead of truncate).
package relu_maxpool2_pkg;

  localparam int IN_W    = 32'sd28;  // raster row stride, including wrap-around columns
  localparam int VALID_W = 32'sd26;  // kept columns per row
  localparam int VALID_H = 32'sd26;  // rows per frame
  localparam int DW_IN   = 32'sd32;  // signed conv sample width
  localparam int DW_OUT  = 32'sd16;  // signed output width
  localparam int SHIFT   = 32'sd12;  // requantisation right shift

  // Post-ReLU values are never negative, so one bit narrower than the input suffices.
  localparam int PW       = DW_IN - 32'sd1;
  localparam int CNT_W    = 32'sd5;
  localparam int IDX_W    = 32'sd4;
  localparam int LB_DEPTH = VALID_W / 32'sd2;

  localparam logic [CNT_W-1:0]  COL_LAST    = CNT_W'(IN_W - 32'sd1);
  localparam logic [CNT_W-1:0]  ROW_LAST    = CNT_W'(VALID_H - 32'sd1);
  localparam logic [CNT_W-1:0]  COL_KEEP    = CNT_W'(VALID_W);
  localparam logic [IDX_W-1:0]  LB_IDX_LAST = IDX_W'(LB_DEPTH - 32'sd1);

  // Largest positive DW_OUT-bit signed value.
  localparam logic [DW_OUT-1:0] SAT_LIMIT   = 16'h7FFF;
  localparam logic [DW_IN:0]    SAT_WIDE    = (DW_IN + 32'sd1)'(SAT_LIMIT);

`ifdef RELU_MAXPOOL_ROUND_EN
  localparam logic [DW_IN:0]    ROUND_ADD   = (DW_IN + 32'sd1)'(33'd1 << (SHIFT - 32'sd1));
`endif

  // Scale a non-negative pooled value down by SHIFT and saturate to the output range.
  // The sum is carried in DW_IN+1 bits so the rounding offset can never overflow.
  function automatic logic [DW_OUT-1:0] requant(input logic [PW-1:0] m);
    logic [DW_IN:0] sum;
    logic [DW_IN:0] q;
`ifdef RELU_MAXPOOL_ROUND_EN
    sum = {2'b00, m} + ROUND_ADD;
`else
    sum = {2'b00, m};
`endif
    q = sum >> SHIFT;
    if (q > SAT_WIDE) begin
      return SAT_LIMIT;
    end else begin
      return q[DW_OUT-1:0];
    end
  endfunction

endpackage

// File: rtl/relu_maxpool2_linebuf.sv
// relu_pool_linebuf: holds one row of horizontal pair maxima between even and odd rows.
// Single write port, asynchronous read. Not reset: every entry is written on an even
// row before the following odd row reads it.
module relu_pool_linebuf
  import relu_maxpool2_pkg::*;
(
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [PW-1:0]    wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [PW-1:0]    rdata_o
);

  logic [PW-1:0] mem_q [LB_DEPTH];

  // Store the even-row pair maximum for its pooling column.
  always_ff @(posedge clk) begin
    if (we_i && (waddr_i <= LB_IDX_LAST)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Column indices past the last pool column (wrap-around columns) read as zero.
  assign rdata_o = (raddr_i <= LB_IDX_LAST) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/relu_maxpool2.sv
// relu_maxpool2: drops wrap-around columns of the conv raster, applies ReLU, pools 2x2
// with stride 2 and requantises to 16-bit signed. One output per 2x2 window, raster order.
// Optional feature macro: RELU_MAXPOOL_ROUND_EN (see relu_maxpool2_pkg::requant).
module relu_maxpool2
  import relu_maxpool2_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DW_IN-1:0]  data_in,
  output logic                     out_valid,
  output logic signed [DW_OUT-1:0] data_out,
  output logic                     frame_done
);

  logic [CNT_W-1:0]  col_q,  col_d;
  logic [CNT_W-1:0]  row_q,  row_d;
  logic [PW-1:0]     pair_q, pair_d;
  logic              ov_q,   ov_d;
  logic [DW_OUT-1:0] dout_q, dout_d;
  logic              fd_q,   fd_d;

  logic [PW-1:0]     relu_s;
  logic [PW-1:0]     h_s;
  logic [PW-1:0]     m_s;
  logic [PW-1:0]     lb_rd_s;
  logic              lb_we_s;
  logic              kept_s;

  relu_pool_linebuf u_linebuf (
    .clk     (clk),
    .we_i    (lb_we_s),
    .waddr_i (col_q[CNT_W-1:1]),
    .wdata_i (h_s),
    .raddr_i (col_q[CNT_W-1:1]),
    .rdata_o (lb_rd_s)
  );

  // Datapath and raster bookkeeping for the sample presented this cycle.
  always_comb begin
    relu_s  = data_in[DW_IN-1] ? '0 : data_in[PW-1:0];
    h_s     = (relu_s > pair_q) ? relu_s : pair_q;
    m_s     = (lb_rd_s > h_s) ? lb_rd_s : h_s;
    kept_s  = (col_q < COL_KEEP);

    col_d   = col_q;
    row_d   = row_q;
    pair_d  = pair_q;
    ov_d    = 1'b0;
    dout_d  = dout_q;
    fd_d    = 1'b0;
    lb_we_s = 1'b0;

    if (in_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : (row_q + 5'd1);
        fd_d  = (row_q == ROW_LAST);
      end else begin
        col_d = col_q + 5'd1;
        row_d = row_q;
      end

      if (kept_s) begin
        if (!col_q[0]) begin
          pair_d = relu_s;              // left half of the horizontal pair
        end else if (!row_q[0]) begin
          lb_we_s = 1'b1;               // top row of the window: park it
        end else begin
          ov_d   = 1'b1;                // bottom-right of the window: emit
          dout_d = requant(m_s);
        end
      end else begin
        pair_d = pair_q;                // wrap-around columns are consumed only
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // State and output registers; reset clears counters and pulses immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      pair_q <= '0;
      ov_q   <= 1'b0;
      dout_q <= '0;
      fd_q   <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      pair_q <= pair_d;
      ov_q   <= ov_d;
      dout_q <= dout_d;
      fd_q   <= fd_d;
    end
  end

  assign out_valid  = ov_q;
  assign data_out   = dout_q;
  assign frame_done = fd_q;

endmodule
